// File: rtl/bias_add_stream.sv
// bias_add_stream: loads NUM_CH per-channel biases from a FIFO, then adds them
// to the channel-interleaved accumulator stream with signed saturation.
// The biases are reloaded for every frame.
// Optional feature: define BIAS_ADD_RELU_EN to force negative results to zero.
module bias_add_stream #(
  parameter int NUM_CH        = 16,
  parameter int COEFF_W       = 16,
  parameter int DATA_W        = 16,
  parameter int PIX_PER_FRAME = 64
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic [COEFF_W-1:0] bias_V_dout,
  input  logic               bias_V_empty_n,
  output logic               bias_V_read,
  input  logic [DATA_W-1:0]  input_V_dout,
  input  logic               input_V_empty_n,
  output logic               input_V_read,
  output logic [DATA_W-1:0]  output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PIX_W = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
  localparam int SUM_W = ((DATA_W > COEFF_W) ? DATA_W : COEFF_W) + 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_PER_FRAME - 1);

  // Clamp limits of the output word, widened to the sum width
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {
    LOAD,
    RUN
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [CH_W-1:0]     ch_cnt;
  logic [PIX_W-1:0]    pix_cnt;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [COEFF_W-1:0]  bias_mem [NUM_CH];
  logic [COEFF_W-1:0]  bias_sel;
  logic                bias_pop;
  logic                in_pop;
  logic                slot_free;
  logic                ch_last;
  logic                frame_last;
  logic signed [SUM_W-1:0] sum;
  logic [DATA_W-1:0]   result;

  assign ch_last        = (ch_cnt == CH_LAST);
  assign frame_last     = ch_last && (pix_cnt == PIX_LAST);
  assign bias_pop       = bias_V_read;
  assign in_pop         = input_V_read;
  assign output_V_write = out_valid;
  assign output_V_din   = out_data;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and FIFO handshakes; reads are gated off while reset is held
  always_comb begin
    state_next   = state;
    bias_V_read  = 1'b0;
    input_V_read = 1'b0;
    slot_free    = !out_valid || output_V_full_n;
    case (state)
      LOAD: begin
        bias_V_read = bias_V_empty_n && ap_rst_n;
        if (bias_V_empty_n && ch_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        input_V_read = input_V_empty_n && slot_free && ap_rst_n;
        if (input_V_read && frame_last) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Channel index while loading; channel and pixel position while running
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ch_cnt  <= '0;
      pix_cnt <= '0;
    end else if (bias_pop) begin
      ch_cnt <= ch_last ? '0 : ch_cnt + 1'b1;
    end else if (in_pop) begin
      if (ch_last) begin
        ch_cnt  <= '0;
        pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Bias register file; contents are don't-care until loaded, so no reset
  always_ff @(posedge ap_clk) begin
    if (bias_pop) begin
      bias_mem[ch_cnt] <= bias_V_dout;
    end
  end

  // Widened signed add of accumulator and bias, then clamp to the output range
  always_comb begin
    bias_sel = bias_mem[ch_cnt];
    sum = {{(SUM_W-DATA_W){input_V_dout[DATA_W-1]}}, input_V_dout}
        + {{(SUM_W-COEFF_W){bias_sel[COEFF_W-1]}}, bias_sel};
    if (sum > SAT_MAX) begin
      result = SAT_MAX[DATA_W-1:0];
    end else if (sum < SAT_MIN) begin
      result = SAT_MIN[DATA_W-1:0];
    end else begin
      result = sum[DATA_W-1:0];
    end
`ifdef BIAS_ADD_RELU_EN
    if (result[DATA_W-1]) begin
      result = '0;
    end
`endif
  end

  // Output holding register: reload on every pop, empty once drained downstream
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_pop) begin
      out_data  <= result;
      out_valid <= 1'b1;
    end else if (out_valid && output_V_full_n) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_add_stream.sv
// tb_bias_add_stream: randomized FIFO traffic against a queue-based model of
// per-frame bias loading, bias-add with saturation and ordered output delivery.
module tb_bias_add_stream;

  localparam int NUM_CH  = 16;
  localparam int COEFF_W = 16;
  localparam int DATA_W  = 16;
  localparam int PIX     = 4;
  localparam int WORDS   = NUM_CH * PIX;
  localparam int OUT_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (DATA_W - 1));
`ifdef BIAS_ADD_RELU_EN
  localparam int PIN_LO = 0;
`else
  localparam int PIN_LO = OUT_MIN;
`endif

  logic               ap_clk = 1'b0;
  logic               ap_rst_n = 1'b0;
  logic [COEFF_W-1:0] bias_V_dout = '0;
  logic               bias_V_empty_n = 1'b0;
  logic               bias_V_read;
  logic [DATA_W-1:0]  input_V_dout = '0;
  logic               input_V_empty_n = 1'b0;
  logic               input_V_read;
  logic [DATA_W-1:0]  output_V_din;
  logic               output_V_full_n = 1'b1;
  logic               output_V_write;

  bias_add_stream #(
    .NUM_CH(NUM_CH), .COEFF_W(COEFF_W), .DATA_W(DATA_W), .PIX_PER_FRAME(PIX)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
    .input_V_dout(input_V_dout), .input_V_empty_n(input_V_empty_n), .input_V_read(input_V_read),
    .output_V_din(output_V_din), .output_V_full_n(output_V_full_n), .output_V_write(output_V_write)
  );

  always #5 ap_clk = ~ap_clk;

  // Model state: source FIFOs, expected results in order, frame progress
  int bias_q[$];
  int in_q[$];
  int exp_q[$];
  int checks = 0;
  int errors = 0;
  int bias_frame_cnt = 0;
  int in_frame_cnt = 0;
  int held = 0;
  int dut_bias_pops = 0;
  int dut_in_cnt = 0;
  int bias_mode = 0;
  int in_mode = 0;
  int full_mode = 0;
  int stall_cnt = 0;
  bit toggle_ph = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_in_pop = 1'b0;
  int prev_din = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic int modelResult(input int data, input int bias);
    int s;
    s = data + bias;
    if (s > OUT_MAX) s = OUT_MAX;
    if (s < OUT_MIN) s = OUT_MIN;
`ifdef BIAS_ADD_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic int randWord();
    int sel;
    sel = int'($urandom_range(0, 5));
    if (sel == 0) return OUT_MAX;
    if (sel == 1) return OUT_MIN;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic pushFrame(input int b [NUM_CH], input int d [WORDS]);
    for (int i = 0; i < NUM_CH; i++) bias_q.push_back(b[i]);
    for (int k = 0; k < WORDS; k++) begin
      in_q.push_back(d[k]);
      exp_q.push_back(modelResult(d[k], b[k % NUM_CH]));
    end
  endtask

  task automatic pushRandomFrame();
    int b [NUM_CH];
    int d [WORDS];
    for (int i = 0; i < NUM_CH; i++) b[i] = randWord();
    for (int k = 0; k < WORDS; k++) d[k] = randWord();
    pushFrame(b, d);
  endtask

  // Drive the FIFO-side inputs for the coming clock edge
  task automatic applyStimulus();
    bit avail;
    case (bias_mode)
      0: avail = 1'b1;
      1: avail = ($urandom_range(0, 1) != 0);
      default: begin toggle_ph = !toggle_ph; avail = toggle_ph; end
    endcase
    bias_V_empty_n = avail && (bias_q.size() > 0);
    bias_V_dout = bias_V_empty_n ? COEFF_W'(bias_q[0]) : COEFF_W'($urandom);
    avail = (in_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    input_V_empty_n = avail && (in_q.size() > 0);
    input_V_dout = input_V_empty_n ? DATA_W'(in_q[0]) : DATA_W'($urandom);
    if (stall_cnt > 0) begin
      output_V_full_n = 1'b0;
      stall_cnt--;
    end else begin
      output_V_full_n = (full_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  endtask

  // Compare DUT against the model mid-cycle, then commit the handshakes
  task automatic monitorCycle();
    bit load_phase;
    bit b_pop;
    bit i_pop;
    bit xfer;
    load_phase = (bias_frame_cnt < NUM_CH);
    b_pop = load_phase && bias_V_empty_n;
    i_pop = !load_phase && input_V_empty_n && (held == 0 || output_V_full_n);
    xfer  = (held > 0) && output_V_full_n;
    checkOutput("bias_read", int'(bias_V_read), int'(b_pop));
    checkOutput("input_read", int'(input_V_read), int'(i_pop));
    checkOutput("out_write", int'(output_V_write), int'(held > 0));
    if (prev_in_pop) checkOutput("latency_write", int'(output_V_write), 1);
    if (prev_stall) checkOutput("stall_hold_din", int'($signed(output_V_din)), prev_din);
    if (bias_V_read && bias_V_empty_n) dut_bias_pops++;
    if (input_V_read && input_V_empty_n) begin
      if (dut_in_cnt == 0) checkOutput("bias_pops_per_frame", dut_bias_pops, NUM_CH);
      dut_in_cnt++;
      if (dut_in_cnt == WORDS) begin
        dut_in_cnt = 0;
        dut_bias_pops = 0;
      end
    end
    if (xfer) begin
      if (exp_q.size() == 0) checkOutput("unexpected_word", int'($signed(output_V_din)), 0);
      else checkOutput("out_word", int'($signed(output_V_din)), exp_q.pop_front());
    end
    prev_stall  = (held > 0) && !output_V_full_n;
    prev_din    = int'($signed(output_V_din));
    prev_in_pop = i_pop;
    if (b_pop) begin
      void'(bias_q.pop_front());
      bias_frame_cnt++;
    end
    if (i_pop) begin
      void'(in_q.pop_front());
      in_frame_cnt++;
      if (in_frame_cnt == WORDS) begin
        in_frame_cnt = 0;
        bias_frame_cnt = 0;
      end
    end
    held = held - int'(xfer) + int'(i_pop);
  endtask

  task automatic stepCycle();
    @(posedge ap_clk);
    #1;
    applyStimulus();
    @(negedge ap_clk);
    monitorCycle();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic waitInputs(input int target, input int budget);
    int n;
    n = 0;
    while (in_frame_cnt < target && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("wait_timeout", int'(in_frame_cnt >= target), 1);
  endtask

  // Assert reset away from the clock edge, verify quiet outputs, restart the model
  task automatic resetAndCheck(input string tag);
    ap_rst_n = 1'b0;
    bias_V_empty_n = 1'b1;
    input_V_empty_n = 1'b1;
    output_V_full_n = 1'b1;
    #1;
    checkOutput({tag, "_bias_read"}, int'(bias_V_read), 0);
    checkOutput({tag, "_input_read"}, int'(input_V_read), 0);
    checkOutput({tag, "_write"}, int'(output_V_write), 0);
    checkOutput({tag, "_din"}, int'(output_V_din), 0);
    bias_V_empty_n = 1'b0;
    input_V_empty_n = 1'b0;
    bias_q.delete();
    in_q.delete();
    exp_q.delete();
    bias_frame_cnt = 0;
    in_frame_cnt = 0;
    held = 0;
    dut_bias_pops = 0;
    dut_in_cnt = 0;
    prev_stall = 1'b0;
    prev_in_pop = 1'b0;
    stall_cnt = 0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    int b [NUM_CH];
    int d [WORDS];
    int base;

    #2;
    resetAndCheck("reset");

    checkOutput("pin_model_hi", modelResult(32767, 5), 32767);
    checkOutput("pin_model_lo", modelResult(-32768, -1), PIN_LO);
    checkOutput("pin_model_mid", modelResult(100, 15), 115);
`ifdef BIAS_ADD_RELU_EN
    checkOutput("pin_model_relu", modelResult(-50, 10), 0);
`endif

    $display("[TB] frame A: biases 0..15, inputs 100, no backpressure");
    for (int i = 0; i < NUM_CH; i++) b[i] = i;
    for (int k = 0; k < WORDS; k++) d[k] = 100;
    pushFrame(b, d);
    checkOutput("pin_first", exp_q[0], 100);
    checkOutput("pin_ch15", exp_q[15], 115);
    checkOutput("pin_last", exp_q[WORDS-1], 115);
    drain(1000);

    $display("[TB] frame B: saturation at both ends, random handshakes");
    bias_mode = 1; in_mode = 1; full_mode = 1;
    for (int i = 0; i < NUM_CH; i++) b[i] = randWord();
    for (int k = 0; k < WORDS; k++) d[k] = randWord();
    b[0] = 5;  d[0] = 32767;
    b[1] = -1; d[1] = -32768;
    base = exp_q.size();
    pushFrame(b, d);
    checkOutput("pin_sat_hi", exp_q[base], 32767);
    checkOutput("pin_sat_lo", exp_q[base+1], PIN_LO);
    drain(3000);

    $display("[TB] frame C: 10-cycle output stall mid-run");
    bias_mode = 0; in_mode = 0; full_mode = 0;
    pushRandomFrame();
    waitInputs(10, 500);
    stall_cnt = 10;
    drain(1000);

    $display("[TB] frames D+E: toggling bias availability, back-to-back frames");
    bias_mode = 2; in_mode = 0; full_mode = 1;
    pushRandomFrame();
    pushRandomFrame();
    drain(3000);

    $display("[TB] frame F: reset mid-run, then frame G");
    bias_mode = 1; in_mode = 1; full_mode = 1;
    pushRandomFrame();
    waitInputs(20, 2000);
    #2;
    resetAndCheck("midreset");
    pushRandomFrame();
    drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
